jpeg_stream_reader: RTL and testbench
=====================================

Name: jpeg_stream_reader

Overview:
- Bus initiator that drains the JPEG encoder's compressed-bitstream FIFO over the peripheral crossbar and presents the data as a valid/ready word stream, e.g. to a DMA or packer.
- Polls the encoder's FIFO_DEPTH register and reads DATA_FIFO words in bursts. After the encoder's end interrupt, it reads END_BITS and tags the final word with its valid-bit count.
- Replaces software draining of the encoder, so a frame is encoded without CPU involvement.

Parameters:
- BASE_ADDR, 32'h0, byte address of the encoder window; add[9:8] selects 00=DATA_FIFO, 10=FIFO_DEPTH, 11=END_BITS.
- ID_WIDTH, 4, transaction id width.
- MAX_BURST, 8, maximum data reads issued per depth poll (1..16).
- POLL_GAP, 16, idle cycles between polls that return depth 0 (>=1).
- BUF_DEPTH, 4, internal output buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  pulse; begins a frame when idle
- end_irq  in  1  encoder end_interrupt (1-cycle pulse)
- m_req  out  1  bus request
- m_add  out  32  bus address
- m_wen  out  1  always 1 (read)
- m_wdata  out  32  always 0
- m_be  out  4  always 4'hF
- m_id  out  ID_WIDTH  constant 0
- m_gnt  in  1  grant
- m_r_valid  in  1  response valid
- m_r_rdata  in  32  response data
- out_data  out  32  stream word
- out_valid  out  1  stream valid
- out_last  out  1  final word of frame
- out_bits  out  6  valid MSB-aligned bits of out_data (1..32); 32 unless out_last
- out_ready  in  1  stream ready
- busy  out  1  frame in progress
- done  out  1  1-cycle pulse when the last word is accepted
- word_count  out  16  words emitted this frame; saturates at 16'hFFFF
- error  out  1  1-cycle error pulse

Behaviour:
- Reset: all outputs 0 except m_wen=1 and m_be=4'hF; FSM to IDLE; buffer, tail register, end_seen and counters cleared. Reset mid-frame abandons the frame silently.
- Bus rules:
  - m_req and m_add are held until the cycle m_req&&m_gnt.
  - At most one transaction is outstanding; the response is the first m_r_valid after the grant.
  - m_r_valid without an outstanding request is ignored.
- end_seen is set by end_irq in any non-IDLE state, cleared on start. end_irq in IDLE is ignored.
- FSM:
  - IDLE: start -> POLL. start while busy is ignored.
  - POLL: read FIFO_DEPTH; rdata[4:0]=depth.
    - depth>0 -> DATA with n=min(depth,MAX_BURST).
    - depth==0 and end_seen -> END.
    - else -> GAP.
  - end_seen is sampled at the depth response. end_irq arriving while depth>0 is handled by the next poll.
  - GAP: count POLL_GAP cycles -> POLL.
  - DATA: issue a read only when the buffer has a free entry. Each response is pushed to the buffer. After n responses -> POLL.
  - END: read END_BITS once (this read also resets the encoder). c=rdata[4:0]; bits = (c==0)?32:c. -> FLUSH.
  - FLUSH: release the tail word with out_last=1 and out_bits=bits. On accept: done pulse -> IDLE.
  - If the frame had no data words, FLUSH emits nothing, pulses done, and -> IDLE.
- Tail hold:
  - The newest buffered word is not presented downstream until a newer word arrives or FLUSH, so out_last is attached to the correct word.
  - Effective stream capacity is BUF_DEPTH-1 words plus the tail.
- Stream: standard valid/ready. out_data, out_last and out_bits are stable while out_valid&&!out_ready. word_count increments on each accept.
- busy=1 from start accept until the cycle after done.
- Data order is preserved end-to-end; no word is dropped or duplicated under any out_ready pattern.

Optional Feature:
- JPEG_RD_TIMEOUT_EN: adds a 10-bit watchdog.
  - Triggers if m_r_valid does not arrive within 1023 cycles of a grant, or m_gnt stays low for 1023 cycles with m_req high.
  - On trigger: pulse error, drop m_req, clear buffer and tail, FSM -> IDLE, busy=0, no done.
- Without the macro: waits indefinitely; error is tied 0.

Test Plan:
- Single frame: encoder model with depth sequence 5,0 then end_irq, 5 data words, END_BITS=13, out_ready=1 -> 5 words in order; last has out_last=1, out_bits=13; done pulse; word_count=5.
- Burst cap: MAX_BURST=8, depth 20 -> polls read 8, 8, 4 words; exactly 20 DATA reads; never two outstanding.
- Backpressure: out_ready toggling 1-in-3, 40 words -> no loss or duplication; m_req stalls when the buffer is full; output held stable while stalled.
- Empty frame: end_irq with depth 0 and END_BITS=0 -> no stream words, done pulse, word_count=0; exactly one END_BITS read.
- Full last word: END_BITS=0 after 3 words -> third word out_bits=32, out_last=1.
- Reset mid-DATA, then start -> outputs are at reset values immediately; the next frame behaves as the single-frame case (with JPEG_RD_TIMEOUT_EN: no r_valid for 1023 cycles -> error pulse, back to IDLE).

Source files
------------

// File: rtl/jpeg_stream_reader.sv
// JPEG encoder bitstream drain: polls FIFO_DEPTH, burst-reads DATA_FIFO into a small buffer and
// streams it out, tagging the final word with END_BITS. Define JPEG_RD_TIMEOUT_EN for the read watchdog.
`timescale 1ns/1ps
module jpeg_stream_reader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned POLL_GAP  = 16,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                end_irq,
    output logic                m_req,
    output logic [31:0]         m_add,
    output logic                m_wen,
    output logic [31:0]         m_wdata,
    output logic [3:0]          m_be,
    output logic [ID_WIDTH-1:0] m_id,
    input  logic                m_gnt,
    input  logic                m_r_valid,
    input  logic [31:0]         m_r_rdata,
    output logic [31:0]         out_data,
    output logic                out_valid,
    output logic                out_last,
    output logic [5:0]          out_bits,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         word_count,
    output logic                error
);
    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned GW = $clog2(POLL_GAP + 1);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(BUF_DEPTH);
    localparam logic [4:0]  BURST_MAX = 5'(MAX_BURST);
    localparam logic [31:0] ADDR_DATA  = BASE_ADDR;
    localparam logic [31:0] ADDR_DEPTH = BASE_ADDR + 32'h200;
    localparam logic [31:0] ADDR_END   = BASE_ADDR + 32'h300;

    typedef enum logic [2:0] {S_IDLE, S_POLL, S_GAP, S_DATA, S_END, S_FLUSH} state_t;
    state_t state;

    logic [31:0]   mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   cnt;
    logic          pend, end_seen;
    logic [4:0]    burst_n, issued, recvd;
    logic [5:0]    tail_bits;
    logic [GW-1:0] gap_cnt;
    logic          rsp, push, pop, wd_fire;
    logic [4:0]    rsp_low;

    assign m_wen   = 1'b1;
    assign m_wdata = '0;
    assign m_be    = 4'hF;
    assign m_id    = '0;

    assign rsp     = pend && m_r_valid;
    assign rsp_low = m_r_rdata[4:0];
    assign push    = (state == S_DATA) && rsp;

    // The newest word stays hidden until a newer one arrives or FLUSH decides it is the last.
    assign out_valid = (cnt > CNT_ONE) || ((state == S_FLUSH) && (cnt != '0));
    assign out_last  = (state == S_FLUSH) && (cnt == CNT_ONE);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign out_bits  = !out_valid ? 6'd0 : (out_last ? tail_bits : 6'd32);
    assign pop       = out_valid && out_ready;

`ifdef JPEG_RD_TIMEOUT_EN
    logic [9:0] wd_cnt;
    logic       wd_run;

    assign wd_run  = (m_req && !m_gnt) || (pend && !m_r_valid);
    assign wd_fire = wd_run && (wd_cnt == 10'd1022);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_cnt <= '0;
        else if (!wd_run || wd_fire)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 10'd1;
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= m_r_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            m_req      <= 1'b0;
            m_add      <= '0;
            pend       <= 1'b0;
            end_seen   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            burst_n    <= '0;
            issued     <= '0;
            recvd      <= '0;
            tail_bits  <= '0;
            gap_cnt    <= '0;
        end else if (wd_fire) begin
            state    <= S_IDLE;
            m_req    <= 1'b0;
            pend     <= 1'b0;
            end_seen <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;

            if (m_req && m_gnt) begin
                m_req <= 1'b0;
                pend  <= 1'b1;
            end
            if (rsp)
                pend <= 1'b0;

            if (end_irq && (state != S_IDLE))
                end_seen <= 1'b1;

            case (state)
                S_IDLE: begin
                    // busy drops one cycle after done; a start landing on that cycle is ignored
                    if (busy)
                        busy <= 1'b0;
                    else if (start) begin
                        busy       <= 1'b1;
                        end_seen   <= 1'b0;
                        word_count <= '0;
                        state      <= S_POLL;
                    end
                end
                S_POLL: begin
                    if (rsp) begin
                        if (rsp_low != '0) begin
                            burst_n <= (rsp_low > BURST_MAX) ? BURST_MAX : rsp_low;
                            issued  <= '0;
                            recvd   <= '0;
                            state   <= S_DATA;
                        end else if (end_seen)
                            state <= S_END;
                        else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end else if (!m_req && !pend) begin
                        m_req <= 1'b1;
                        m_add <= ADDR_DEPTH;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(POLL_GAP - 1))
                        state <= S_POLL;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                S_DATA: begin
                    if (rsp) begin
                        recvd <= recvd + 5'd1;
                        if (recvd + 5'd1 == burst_n)
                            state <= S_POLL;
                    end else if (!m_req && !pend && (issued != burst_n) && (cnt < CNT_FULL)) begin
                        m_req  <= 1'b1;
                        m_add  <= ADDR_DATA;
                        issued <= issued + 5'd1;
                    end
                end
                S_END: begin
                    if (rsp) begin
                        tail_bits <= (rsp_low == '0) ? 6'd32 : {1'b0, rsp_low};
                        state     <= S_FLUSH;
                    end else if (!m_req && !pend) begin
                        m_req <= 1'b1;
                        m_add <= ADDR_END;
                    end
                end
                S_FLUSH: begin
                    if ((cnt == '0) || (pop && (cnt == CNT_ONE))) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (word_count != 16'hFFFF)
                    word_count <= word_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_jpeg_stream_reader.sv
// Directed bench for jpeg_stream_reader: encoder bus model, stream sink and per-frame checks.
`timescale 1ns/1ps
module tb_jpeg_stream_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        end_irq = 1'b0;
    logic        m_req, m_wen;
    logic [31:0] m_add, m_wdata;
    logic [3:0]  m_be, m_id;
    logic        m_gnt = 1'b0;
    logic        m_r_valid = 1'b0;
    logic [31:0] m_r_rdata = '0;
    logic [31:0] out_data;
    logic        out_valid, out_last;
    logic [5:0]  out_bits;
    logic        out_ready = 1'b0;
    logic        busy, done, error;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    jpeg_stream_reader #(
        .BASE_ADDR(32'h0), .ID_WIDTH(4), .MAX_BURST(8), .POLL_GAP(16), .BUF_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .end_irq(end_irq),
        .m_req(m_req), .m_add(m_add), .m_wen(m_wen), .m_wdata(m_wdata), .m_be(m_be), .m_id(m_id),
        .m_gnt(m_gnt), .m_r_valid(m_r_valid), .m_r_rdata(m_r_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_bits(out_bits),
        .out_ready(out_ready), .busy(busy), .done(done), .word_count(word_count), .error(error)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- encoder / bus model ----------------
    int          enc_avail, enc_next, frame_id;
    logic [4:0]  enc_end_bits;
    int          data_reads, depth_polls, end_reads, zero_polls, cur_burst;
    int          bursts[$];
    bit          resp_pend = 0;
    int          resp_wait, lat_sel = 0, gnt_wait = 0, gnt_seq = 0;
    logic [31:0] resp_data, gnt_addr;
    bit          no_resp = 0;
    bit          spur = 0;
    int          d;
    logic [7:0]  fb;

    always @(negedge clk) begin
        if (rst) begin
            m_gnt     = 1'b0;
            m_r_valid = 1'b0;
            resp_pend = 0;
        end else begin
            m_r_valid = 1'b0;
            if (m_gnt) begin
                m_gnt = 1'b0;
                check("one_outstanding", resp_pend, 0);
                check("bus_const", {m_wen, m_be, m_id, m_wdata[7:0]}, {1'b1, 4'hF, 4'h0, 8'h00});
                resp_pend = 1;
                resp_wait = lat_sel;
                lat_sel   = (lat_sel + 1) % 3;
                case (gnt_addr[9:8])
                    2'b10: begin
                        d = (enc_avail > 31) ? 31 : enc_avail;
                        resp_data = 32'hFFFF_FFE0 | d[31:0];
                        depth_polls++;
                        if (cur_burst > 0) bursts.push_back(cur_burst);
                        cur_burst = 0;
                        if (d == 0) zero_polls++;
                    end
                    2'b00: begin
                        fb = frame_id[7:0];
                        resp_data = {8'hD0, fb, enc_next[15:0]};
                        enc_next++;
                        enc_avail--;
                        data_reads++;
                        cur_burst++;
                    end
                    2'b11: begin
                        resp_data = {27'h7FF_ABC5, enc_end_bits};
                        end_reads++;
                    end
                    default: begin
                        resp_data = '0;
                        check("bus_addr", gnt_addr, 32'h200);
                    end
                endcase
            end else if (m_req) begin
                if (gnt_wait == 0) begin
                    m_gnt    = 1'b1;
                    gnt_addr = m_add;
                    gnt_wait = gnt_seq % 3;
                    gnt_seq++;
                end else
                    gnt_wait--;
            end
            if (resp_pend && !no_resp) begin
                if (resp_wait == 0) begin
                    m_r_valid = 1'b1;
                    m_r_rdata = resp_data;
                    resp_pend = 0;
                end else
                    resp_wait--;
            end else if (spur) begin
                m_r_valid = 1'b1;
                m_r_rdata = 32'h0000_0005;
                spur = 0;
            end
        end
    end

    // ---------------- stream sink ----------------
    typedef struct packed { logic [31:0] d; logic last; logic [5:0] bits; } rec_t;
    rec_t        got_q[$];
    int          rdy_mode = 0, cyc = 0, done_cnt = 0, err_cnt = 0;
    bit          stall = 0, r;
    logic [31:0] held_data;
    logic [6:0]  held_tag;

    always @(negedge clk) begin
        if (rst) begin
            out_ready = 1'b0;
            stall = 0;
        end else begin
            cyc++;
            if (stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held_data);
                check("hold_tag", {out_last, out_bits}, held_tag);
            end
            case (rdy_mode)
                0:       r = 1;
                1:       r = (cyc % 3 == 0);
                2:       r = (cyc % 2 == 0);
                default: r = 0;
            endcase
            if (out_valid && r) got_q.push_back({out_data, out_last, out_bits});
            stall     = out_valid && !r;
            held_data = out_data;
            held_tag  = {out_last, out_bits};
            out_ready = r;
            if (done)  done_cnt++;
            if (error) err_cnt++;
        end
    end

    // ---------------- frame helpers ----------------
    task automatic init_model(input int n, input logic [4:0] eb, input int mode, input int fid);
        got_q.delete();
        bursts.delete();
        enc_avail = n; enc_next = 0; frame_id = fid; enc_end_bits = eb;
        data_reads = 0; depth_polls = 0; end_reads = 0; zero_polls = 0; cur_burst = 0;
        done_cnt = 0; rdy_mode = mode;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic finish_frame();
        for (int i = 0; i < 20000 && zero_polls == 0; i++) @(negedge clk);
        check("zero_poll_seen", zero_polls > 0, 1);
        @(negedge clk); end_irq = 1'b1;
        @(negedge clk); end_irq = 1'b0;
        for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int n, input logic [4:0] eb, input int fid);
        logic [7:0]  f;
        logic [31:0] exp_d;
        logic [5:0]  exp_b;
        int          rem, eb_n;
        f = fid[7:0];
        check({tag, "_nwords"}, got_q.size(), n);
        for (int i = 0; i < got_q.size() && i < n; i++) begin
            exp_d = {8'hD0, f, i[15:0]};
            exp_b = (i == n - 1) ? ((eb == 5'd0) ? 6'd32 : {1'b0, eb}) : 6'd32;
            check({tag, "_data"}, got_q[i].d, exp_d);
            check({tag, "_last"}, got_q[i].last, i == n - 1);
            check({tag, "_bits"}, got_q[i].bits, exp_b);
        end
        check({tag, "_word_count"}, word_count, n);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_end_reads"}, end_reads, 1);
        check({tag, "_data_reads"}, data_reads, n);
        check({tag, "_nbursts"}, bursts.size(), (n + 7) / 8);
        rem = n;
        for (int j = 0; j < bursts.size(); j++) begin
            eb_n = (rem > 8) ? 8 : rem;
            check({tag, "_burst_len"}, bursts[j], eb_n);
            rem -= eb_n;
        end
    endtask

    typedef struct { int n; logic [4:0] eb; int mode; } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{n: 5,  eb: 5'd13, mode: 0};   // single frame
        vecs[1] = '{n: 20, eb: 5'd7,  mode: 0};   // burst cap 8,8,4
        vecs[2] = '{n: 40, eb: 5'd21, mode: 1};   // backpressure 1-in-3
        vecs[3] = '{n: 0,  eb: 5'd0,  mode: 0};   // empty frame
        vecs[4] = '{n: 3,  eb: 5'd0,  mode: 2};   // full last word
        vecs[5] = '{n: 1,  eb: 5'd31, mode: 1};   // single word frame

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_m_req", m_req, 0);
        check("rst_m_add", m_add, 0);
        check("rst_m_wen", m_wen, 1);
        check("rst_m_be", m_be, 4'hF);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_m_id", m_id, 0);
        check("rst_stream", {out_valid, out_last, out_bits}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_status", {busy, done, error}, 0);
        check("rst_word_count", word_count, 0);
        rst = 1'b0;

        @(negedge clk);
        spur = 1;
        end_irq = 1'b1;
        @(negedge clk);
        end_irq = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_ignore", {m_req, busy, out_valid}, 0);

        for (int k = 0; k < 6; k++) begin
            init_model(vecs[k].n, vecs[k].eb, vecs[k].mode, k + 1);
            pulse_start();
            finish_frame();
            check_frame($sformatf("vec%0d", k), vecs[k].n, vecs[k].eb, k + 1);
        end

        // Buffer full: reads stop at BUF_DEPTH and the head word is held.
        init_model(10, 5'd9, 3, 20);
        pulse_start();
        repeat (300) @(negedge clk);
        check("stall_data_reads", data_reads, 4);
        check("stall_m_req", m_req, 0);
        check("stall_valid", out_valid, 1);
        check("stall_head", out_data, {8'hD0, 8'd20, 16'd0});
        rdy_mode = 0;
        finish_frame();
        check_frame("stall", 10, 5'd9, 20);

        // Reset in the middle of a data burst.
        init_model(10, 5'd13, 0, 30);
        pulse_start();
        for (int i = 0; i < 2000 && data_reads < 2; i++) @(negedge clk);
        check("mid_reads_seen", data_reads >= 2, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_bus", {m_req, m_wen, m_be}, {1'b1, 4'hF});
        check("mid_rst_stream", {out_valid, out_last, out_bits}, 0);
        check("mid_rst_status", {busy, done, error}, 0);
        check("mid_rst_word_count", word_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        init_model(5, 5'd13, 0, 31);
        pulse_start();
        finish_frame();
        check_frame("after_rst", 5, 5'd13, 31);
        check("no_error_pulses", err_cnt, 0);

`ifdef JPEG_RD_TIMEOUT_EN
        init_model(5, 5'd13, 0, 40);
        no_resp = 1;
        pulse_start();
        for (int i = 0; i < 1500 && err_cnt == 0; i++) @(negedge clk);
        check("wd_error", err_cnt, 1);
        repeat (3) @(negedge clk);
        check("wd_busy", busy, 0);
        check("wd_m_req", m_req, 0);
        check("wd_no_done", done_cnt, 0);
        no_resp = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
